alu_cmd_sequencer: RTL and testbench

Sits between the byte-stream packet source and the ALU bfm.
- Accepts a stream of bytes grouped in triples (op, A, B).
- Drives A_s/B_s/op_s with a one-cycle start pulse, then waits for done.
- Returns each captured result on an output stream.
- Replaces the testbench-side array indexing with synthesizable handshake logic and adds timeout and framing-error detection.

---
 rtl/alu_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects (op, A, B) byte triples from an input stream,
// issues one ALU command at a time with a start strobe, waits for done (with
// optional timeout) and returns each result on an output stream.
module alu_cmd_sequencer #(
   parameter int unsigned ITEM_WIDTH     = 8,
   parameter int unsigned OP_WIDTH       = 3,
   parameter int unsigned RES_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [ITEM_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic [ITEM_WIDTH-1:0] A_s,
   output logic [ITEM_WIDTH-1:0] B_s,
   output logic [OP_WIDTH-1:0]   op_s,
   output logic                  start,
   input  logic                  done,
   input  logic [RES_WIDTH-1:0]  res_i,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [RES_WIDTH-1:0]  m_tdata,
   output logic                  m_tlast,
   output logic [CNT_WIDTH-1:0]  cmd_cnt_o,
   output logic                  err_o
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      GET_OP,
      GET_A,
      GET_B,
      ISSUE,
      WAIT_DONE,
      PUSH_RES
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_active;
   logic [OP_WIDTH-1:0]   r_op;
   logic [ITEM_WIDTH-1:0] r_a;
   logic [ITEM_WIDTH-1:0] r_b;
   logic                  r_last;
   logic [RES_WIDTH-1:0]  r_result;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_err;
   logic [TO_W-1:0]       r_to_cnt;

   logic w_in_beat;
   logic w_frame_err;
   logic w_done_take;
   logic w_timeout;
   logic w_out_beat;
   logic w_to_hit;

   // Expiry fires in the WAIT_DONE cycle whose count completes TIMEOUT_CYCLES cycles.
   assign w_to_hit = (TIMEOUT_CYCLES != 0) && ((32'(r_to_cnt) + 32'd1) == TIMEOUT_CYCLES);

   assign A_s       = r_a;
   assign B_s       = r_b;
   assign op_s      = r_op;
   assign m_tdata   = r_result;
   assign m_tlast   = m_tvalid & r_last;
   assign cmd_cnt_o = r_cnt;
   assign err_o     = r_err;

   // State register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_state <= GET_OP;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode and handshake outputs; r_active keeps s_tready low while in reset.
   always_comb begin
      w_state_nxt = r_state;
      s_tready    = 1'b0;
      start       = 1'b0;
      m_tvalid    = 1'b0;
      w_in_beat   = 1'b0;
      w_frame_err = 1'b0;
      w_done_take = 1'b0;
      w_timeout   = 1'b0;
      w_out_beat  = 1'b0;
      case (r_state)
         GET_OP: begin
            s_tready  = r_active;
            w_in_beat = s_tvalid & r_active;
            if (w_in_beat) begin
               if (s_tlast) w_frame_err = 1'b1;
               else         w_state_nxt = GET_A;
            end
         end
         GET_A: begin
            s_tready  = r_active;
            w_in_beat = s_tvalid & r_active;
            if (w_in_beat) begin
               if (s_tlast) begin
                  w_frame_err = 1'b1;
                  w_state_nxt = GET_OP;
               end else begin
                  w_state_nxt = GET_B;
               end
            end
         end
         GET_B: begin
            s_tready  = r_active;
            w_in_beat = s_tvalid & r_active;
            if (w_in_beat) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            start       = 1'b1;
            w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done) begin
               w_done_take = 1'b1;
               w_state_nxt = PUSH_RES;
            end else if (w_to_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = PUSH_RES;
            end
         end
         PUSH_RES: begin
            m_tvalid = 1'b1;
            if (m_tready) begin
               w_out_beat  = 1'b1;
               w_state_nxt = GET_OP;
            end
         end
         default: w_state_nxt = GET_OP;
      endcase
   end

   // Datapath: operand capture, result capture, counters and sticky error.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_active <= 1'b0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_last   <= 1'b0;
         r_result <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_to_cnt <= '0;
      end else begin
         r_active <= 1'b1;
         case (r_state)
            GET_OP: if (w_in_beat && !s_tlast) r_op <= s_tdata[OP_WIDTH-1:0];
            GET_A:  if (w_in_beat && !s_tlast) r_a <= s_tdata;
            GET_B: begin
               if (w_in_beat) begin
                  r_b    <= s_tdata;
                  r_last <= s_tlast;
               end
            end
            default: ;
         endcase
         if (w_frame_err || w_timeout) r_err <= 1'b1;
         if (w_done_take)    r_result <= res_i;
         else if (w_timeout) r_result <= '1;
         if (w_out_beat) r_cnt <= r_cnt + CNT_WIDTH'(1);
         if ((r_state == WAIT_DONE) && (w_state_nxt == WAIT_DONE) && (TIMEOUT_CYCLES != 0))
            r_to_cnt <= r_to_cnt + TO_W'(1);
         else
            r_to_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: byte-stream source, ALU responder and
// result scoreboard, with one task per scenario.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [7:0]  s_tdata = '0;
   logic        s_tlast = 1'b0;
   logic [7:0]  A_s;
   logic [7:0]  B_s;
   logic [2:0]  op_s;
   logic        start;
   logic        done;
   logic [15:0] res_i;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic [15:0] m_tdata;
   logic        m_tlast;
   logic [15:0] cmd_cnt_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [15:0] exp_q[$];
   logic        exp_l_q[$];

   int bfm_delay = 1;
   bit bfm_en = 1'b1;
   int kick_req = 0;
   int kick_ack = 0;

   int cyc = 0;
   int start_cnt = 0;
   int start_double = 0;
   bit prev_start = 1'b0;
   int start_times[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .ITEM_WIDTH(8),
      .OP_WIDTH(3),
      .RES_WIDTH(16),
      .TIMEOUT_CYCLES(4),
      .CNT_WIDTH(16)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .A_s(A_s), .B_s(B_s), .op_s(op_s), .start(start), .done(done), .res_i(res_i),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .cmd_cnt_o(cmd_cnt_o), .err_o(err_o)
   );

   function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return 16'(a) - 16'(b);
         3'd3:    return 16'(a) * 16'(b);
         3'd4:    return {8'h00, a ^ b};
         3'd5:    return {8'h00, a & b};
         3'd6:    return {8'h00, a | b};
         default: return {a, b};
      endcase
   endfunction

   always @(posedge clk) cyc++;

   // start pulse monitor: count, timestamp, detect pulses wider than one cycle
   always @(negedge clk) begin
      if (start === 1'b1) begin
         start_cnt++;
         start_times.push_back(cyc);
         if (prev_start) start_double++;
      end
      prev_start = (start === 1'b1);
   end

   // ALU responder: done/result bfm_delay cycles after the start cycle, plus stray done pulses on request
   logic [7:0] ba, bb;
   logic [2:0] bo;
   initial begin
      done  = 1'b0;
      res_i = '0;
      forever begin
         @(negedge clk);
         if (start === 1'b1 && bfm_en) begin
            ba = A_s; bb = B_s; bo = op_s;
            @(posedge clk);
            repeat (bfm_delay - 1) @(posedge clk);
            #1 done = 1'b1; res_i = alu_model(bo, ba, bb);
            @(posedge clk);
            #1 done = 1'b0; res_i = '0;
         end else if (kick_req != kick_ack) begin
            kick_ack++;
            @(posedge clk);
            #1 done = 1'b1; res_i = 16'hBEEF;
            @(posedge clk);
            #1 done = 1'b0; res_i = '0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_tready === 1'b1) begin ok = 1'b1; break; end
      end
      if (ok) @(posedge clk);
      #1 s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_byte: accepted %0d required 1 (byte %h)", ok, d);
      end
   endtask

   task automatic send_triple(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic l, input bit push);
      logic [2:0] o;
      o = op[2:0];
      if (push) begin
         exp_q.push_back(alu_model(o, a, b));
         exp_l_q.push_back(l);
      end
      send_byte(op, 1'b0);
      send_byte(a, 1'b0);
      send_byte(b, l);
   endtask

   task automatic wait_result(input int bound, output logic [15:0] d, output logic l, output bit ok);
      ok = 1'b0; d = '0; l = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            d = m_tdata; l = m_tlast; ok = 1'b1;
            break;
         end
      end
      if (ok) begin @(posedge clk); #1; end
   endtask

   task automatic apply_reset();
      reset_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b1;
      exp_cnt = 0;
      exp_q.delete();
      exp_l_q.delete();
   endtask

   task automatic test_reset();
      logic [55:0] v;
      reset_i = 1'b1;
      #2 reset_i = 1'b0;
      @(negedge clk);
      v = {s_tready, A_s, B_s, op_s, start, m_tvalid, m_tdata, m_tlast, cmd_cnt_o, err_o};
      checks++;
      if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
      @(posedge clk); #1 reset_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", s_tready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [15:0] d, e; logic l, el; bit ok; int s0;
      bfm_en = 1'b1; bfm_delay = 2; m_tready = 1'b1; s0 = start_cnt;
      send_triple(8'h01, 8'h05, 8'h03, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (start !== 1'b1) begin errors++; $display("FAIL start_latency: got %b expected 1", start); end
      checks++;
      if ({op_s, A_s, B_s} !== {3'd1, 8'h05, 8'h03})
         begin errors++; $display("FAIL operands: got %h expected %h", {op_s, A_s, B_s}, {3'd1, 8'h05, 8'h03}); end
      wait_result(20, d, l, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_result: valid got 0 expected 1"); end
      else begin
         e = exp_q.pop_front(); el = exp_l_q.pop_front(); exp_cnt++;
         checks++;
         if ({l, d} !== {el, e}) begin errors++; $display("FAIL single_data: got %b/%h expected %b/%h", l, d, el, e); end
      end
      @(negedge clk);
      checks++;
      if ({err_o, cmd_cnt_o} !== {1'b0, 16'(exp_cnt)})
         begin errors++; $display("FAIL single_status: got err %b cnt %0d expected err 0 cnt %0d", err_o, cmd_cnt_o, exp_cnt); end
      checks++;
      if (start_cnt - s0 != 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", start_cnt - s0); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int s0, d0, t0, gap;
      s0 = start_cnt; d0 = start_double; t0 = start_times.size();
      bfm_en = 1'b1; bfm_delay = 1; m_tready = 1'b1;
      fork
         begin
            for (int i = 0; i < 100; i++)
               send_triple(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
         end
         begin
            logic [15:0] d, e; logic l, el; bit ok;
            for (int i = 0; i < 100; i++) begin
               wait_result(60, d, l, ok);
               checks++;
               if (!ok) begin errors++; $display("FAIL b2b_result %0d: valid got 0 expected 1", i); break; end
               e = exp_q.pop_front(); el = exp_l_q.pop_front(); exp_cnt++;
               if ({l, d} !== {el, e}) begin errors++; $display("FAIL b2b_data %0d: got %b/%h expected %b/%h", i, l, d, el, e); end
            end
         end
      join
      @(negedge clk);
      checks++;
      if (cmd_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", cmd_cnt_o, exp_cnt); end
      checks++;
      if (start_cnt - s0 != 100) begin errors++; $display("FAIL b2b_starts: got %0d expected 100", start_cnt - s0); end
      checks++;
      if (start_double != d0) begin errors++; $display("FAIL b2b_start_width: got %0d wide pulses expected 0", start_double - d0); end
      gap = (start_times.size() >= t0 + 100) ? start_times[t0 + 99] - start_times[t0] : -1;
      checks++;
      if (gap != 99 * 6) begin errors++; $display("FAIL b2b_period: got %0d cycles expected %0d", gap, 99 * 6); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [15:0] e; bit ok; int bad, beats;
      m_tready = 1'b0; bfm_delay = 1;
      send_triple(8'h03, 8'h0C, 8'h0B, 1'b0, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_tvalid === 1'b1) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_valid: got 0 expected 1"); end
      e = exp_q.pop_front(); void'(exp_l_q.pop_front());
      bad = 0;
      repeat (10) begin
         if (m_tvalid !== 1'b1 || m_tdata !== e || m_tlast !== 1'b0 || s_tready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0 (data %h expected %h)", bad, m_tdata, e); end
      @(posedge clk); #1 m_tready = 1'b1;
      beats = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_tvalid === 1'b1 && m_tready === 1'b1) beats++;
      end
      exp_cnt++;
      checks++;
      if (beats != 1) begin errors++; $display("FAIL bp_beats: got %0d expected 1", beats); end
      checks++;
      if (cmd_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_count: got %0d expected %0d", cmd_cnt_o, exp_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      logic [15:0] d, e; logic l, el; bit ok; int k, vcount; logic [16:0] got;
      // done on the expiry cycle wins over the timeout
      apply_reset();
      m_tready = 1'b1; bfm_en = 1'b1; bfm_delay = 4;
      send_triple(8'h01, 8'h20, 8'h22, 1'b1, 1'b1);
      wait_result(20, d, l, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL edge_done_valid: got 0 expected 1"); end
      else begin
         e = exp_q.pop_front(); el = exp_l_q.pop_front(); exp_cnt++;
         checks++;
         if ({l, d} !== {el, e}) begin errors++; $display("FAIL edge_done_data: got %b/%h expected %b/%h", l, d, el, e); end
      end
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL edge_done_err: got %b expected 0", err_o); end
      @(posedge clk); #1;
      // done never arrives
      bfm_en = 1'b0;
      send_triple(8'h01, 8'h01, 8'h02, 1'b1, 1'b0);
      k = 0; got = '0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (m_tvalid === 1'b1) begin k = i; got = {m_tlast, m_tdata}; break; end
      end
      if (k != 0) begin @(posedge clk); #1; exp_cnt++; end
      checks++;
      if (k != 6) begin errors++; $display("FAIL timeout_latency: got %0d expected 6", k); end
      checks++;
      if (got !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL timeout_data: got %h expected %h", got, {1'b1, 16'hFFFF}); end
      @(negedge clk);
      checks++;
      if ({err_o, cmd_cnt_o} !== {1'b1, 16'(exp_cnt)})
         begin errors++; $display("FAIL timeout_status: got err %b cnt %0d expected err 1 cnt %0d", err_o, cmd_cnt_o, exp_cnt); end
      kick_req++;
      vcount = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_tvalid !== 1'b0) vcount++;
      end
      checks++;
      if (vcount != 0 || cmd_cnt_o !== 16'(exp_cnt) || s_tready !== 1'b1)
         begin errors++; $display("FAIL stray_done: got %0d valid cycles cnt %0d expected 0 cnt %0d", vcount, cmd_cnt_o, exp_cnt); end
      bfm_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_framing();
      logic [15:0] d, e; logic l, el; bit ok; int s0;
      apply_reset();
      bfm_en = 1'b1; bfm_delay = 1; m_tready = 1'b1; s0 = start_cnt;
      send_byte(8'h04, 1'b0);
      send_byte(8'h09, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if ({err_o, 32'(start_cnt - s0)} !== {1'b1, 32'd0})
         begin errors++; $display("FAIL framing_a: got err %b starts %0d expected err 1 starts 0", err_o, start_cnt - s0); end
      send_byte(8'hAA, 1'b1);
      send_triple(8'h02, 8'h07, 8'h01, 1'b0, 1'b1);
      wait_result(20, d, l, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL framing_next_valid: got 0 expected 1"); end
      else begin
         e = exp_q.pop_front(); el = exp_l_q.pop_front(); exp_cnt++;
         checks++;
         if ({l, d} !== {el, e}) begin errors++; $display("FAIL framing_next_data: got %b/%h expected %b/%h", l, d, el, e); end
      end
      @(negedge clk);
      checks++;
      if (cmd_cnt_o !== 16'(exp_cnt) || start_cnt - s0 != 1)
         begin errors++; $display("FAIL framing_count: got cnt %0d starts %0d expected cnt %0d starts 1", cmd_cnt_o, start_cnt - s0, exp_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [15:0] d, e; logic l, el; bit ok; logic [55:0] v;
      bfm_en = 1'b0; m_tready = 1'b1;
      send_triple(8'h01, 8'h11, 8'h22, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      #1;
      v = {s_tready, A_s, B_s, op_s, start, m_tvalid, m_tdata, m_tlast, cmd_cnt_o, err_o};
      checks++;
      if (v !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", v); end
      @(posedge clk); #1 reset_i = 1'b1;
      exp_cnt = 0; exp_q.delete(); exp_l_q.delete();
      bfm_en = 1'b1; bfm_delay = 1;
      send_triple(8'h05, 8'h0F, 8'h33, 1'b1, 1'b1);
      wait_result(20, d, l, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_after_valid: got 0 expected 1"); end
      else begin
         e = exp_q.pop_front(); el = exp_l_q.pop_front(); exp_cnt++;
         checks++;
         if ({l, d} !== {el, e}) begin errors++; $display("FAIL mid_after_data: got %b/%h expected %b/%h", l, d, el, e); end
      end
      @(negedge clk);
      checks++;
      if ({err_o, cmd_cnt_o} !== {1'b0, 16'd1})
         begin errors++; $display("FAIL mid_after_status: got err %b cnt %0d expected err 0 cnt 1", err_o, cmd_cnt_o); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_framing();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
